// File: rtl/octal_ctrl_pkg.sv
// octal_ctrl_pkg: shared types and constants for the octal run controller.
// Holds the FSM state enum, phase/index widths, carry threshold, rotate helper.
package octal_ctrl_pkg;

  localparam int PHASE_W        = 8;
  localparam int IDX_W          = 3;
  localparam int CARRY_HIGH_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    RUN,
    DRAIN,
    DONE_ST,
    FAULT_ST
  } state_t;

  function automatic logic [PHASE_W-1:0] rotl1(
    input logic [PHASE_W-1:0] v
  );
    return {v[PHASE_W-2:0], v[PHASE_W-1]};
  endfunction

endpackage

// File: rtl/octal_run_controller_enc.sv
// onehot8_encoder: 8->3 encoder, lowest set bit wins, plus one-hot flag.
// Ports: onehot (in), idx (out), valid_onehot (out).
module onehot8_encoder
  import octal_ctrl_pkg::*;
(
  input  logic [PHASE_W-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid_onehot
);

  always_comb begin
    idx = '0;
    priority case (1'b1)
      onehot[0]: idx = 3'd0;
      onehot[1]: idx = 3'd1;
      onehot[2]: idx = 3'd2;
      onehot[3]: idx = 3'd3;
      onehot[4]: idx = 3'd4;
      onehot[5]: idx = 3'd5;
      onehot[6]: idx = 3'd6;
      onehot[7]: idx = 3'd7;
      default:   idx = 3'd0;
    endcase
  end

  assign valid_onehot = (onehot != '0) &&
    ((onehot & (onehot - 1'b1)) == '0);

endmodule

// File: rtl/octal_run_controller.sv
// octal_run_controller: drives an octal one-hot counter for exactly TERMINAL
// steps per START and monitors it. Optional checks: PHASE_FAULT_CHECK_EN.
// In: CLOCK, RESET(n, async), START, TERMINAL, PHASE_IN, CARRY_IN.
// Out: CLOCK_INHIBIT, COUNTER_RESET, PHASE_IDX, TOTAL, BUSY, DONE, FAULT.
module octal_run_controller
  import octal_ctrl_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic [CNT_W-1:0]   TERMINAL,
  input  logic [PHASE_W-1:0] PHASE_IN,
  input  logic               CARRY_IN,
  output logic               CLOCK_INHIBIT,
  output logic               COUNTER_RESET,
  output logic [IDX_W-1:0]   PHASE_IDX,
  output logic [CNT_W-1:0]   TOTAL,
  output logic               BUSY,
  output logic               DONE,
  output logic               FAULT
);

  state_t state_q, state_d;
  logic [PHASE_W-1:0] phase_q;
  logic [CNT_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic adv, issue, fault_hit;
  logic vld_q;

  onehot8_encoder u_enc_q (
    .onehot       (phase_q),
    .idx          (PHASE_IDX),
    .valid_onehot (vld_q)
  );

  assign adv   = PHASE_IN != phase_q;
  assign issue = (state_q == RUN) && (issued_q != t_q);

`ifdef PHASE_FAULT_CHECK_EN
  logic [IDX_W-1:0] idx_in;
  logic vld_in, issued_prev_q, check_on;

  onehot8_encoder u_enc_in (
    .onehot       (PHASE_IN),
    .idx          (idx_in),
    .valid_onehot (vld_in)
  );

  assign check_on = state_q inside {ARM, RUN, DRAIN};
  assign fault_hit = check_on && (
    !vld_in ||
    (CARRY_IN != (idx_in <= IDX_W'(CARRY_HIGH_MAX))) ||
    ((state_q == ARM) && (PHASE_IN != 8'h01)) ||
    (adv && (PHASE_IN != rotl1(phase_q))) ||
    ((state_q == DRAIN) && adv && (total_q == t_q)) ||
    ((state_q == RUN) && issued_prev_q && !adv));

  // remembers that the counter was released last cycle
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) issued_prev_q <= 1'b0;
    else        issued_prev_q <= issue;
  end

  assign FAULT = state_q == FAULT_ST;
  logic unused_vld;
  assign unused_vld = vld_q;
`else
  assign fault_hit = 1'b0;
  assign FAULT     = 1'b0;
  logic unused_in;
  assign unused_in = ^{CARRY_IN, vld_q};
`endif

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    issued_d = issued_q;
    total_d  = total_q;
    unique case (state_q)
      IDLE, FAULT_ST: begin
        if (START) begin
          state_d  = CLEAR;
          t_d      = TERMINAL;
          issued_d = '0;
          total_d  = '0;
        end
      end
      CLEAR: state_d = ARM;
      ARM:   state_d = (t_q == '0) ? DONE_ST : RUN;
      RUN: begin
        if (issue) begin
          issued_d = issued_q + 1'b1;
          if (issued_d == t_q) state_d = DRAIN;
        end
        if (adv && total_q != t_q) total_d = total_q + 1'b1;
      end
      DRAIN: begin
        if (adv && total_q != t_q) total_d = total_q + 1'b1;
        if (total_d == t_q) state_d = DONE_ST;
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a failed check freezes the counts where they stand
    if (fault_hit) begin
      state_d  = FAULT_ST;
      issued_d = issued_q;
      total_d  = total_q;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      phase_q  <= 8'h01;
      t_q      <= '0;
      issued_q <= '0;
      total_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= PHASE_IN;
      t_q      <= t_d;
      issued_q <= issued_d;
      total_q  <= total_d;
    end
  end

  assign CLOCK_INHIBIT = !RESET || !issue;
  assign COUNTER_RESET = !RESET || (state_q == CLEAR);
  assign BUSY  = state_q inside {CLEAR, ARM, RUN, DRAIN};
  assign DONE  = state_q == DONE_ST;
  assign TOTAL = total_q;

endmodule

// File: doc/octal_run_controller.md
Name: octal_run_controller

Overview:
- Downstream controller and monitor for the CD4022-style octal one-hot counter.
- Consumes the counter's 8-bit one-hot phase outputs and carry output.
- Drives the counter's clock-inhibit and reset so that the counter advances exactly a programmed number of steps after each START.
- Reports the phase index and the observed step total, and flags illegal counter behaviour.

Parameters:
CNT_W, 12, width of TERMINAL, TOTAL and the internal issued-step counter.

Ports:
CLOCK  in  1  system clock; the counter runs on the same clock.
RESET  in  1  asynchronous, active-low reset.
START  in  1  request a run; sampled only in IDLE or FAULT_ST.
TERMINAL  in  CNT_W  number of counter steps per run; captured on the accepted START edge.
PHASE_IN  in  8  counter one-hot outputs.
CARRY_IN  in  1  counter carry output.
CLOCK_INHIBIT  out  1  to counter; 1 = counter frozen.
COUNTER_RESET  out  1  to counter; active-high.
PHASE_IDX  out  3  binary index of the last sampled PHASE_IN.
TOTAL  out  CNT_W  observed steps in the current or last run.
BUSY  out  1  high in CLEAR, ARM, RUN and DRAIN.
DONE  out  1  one-cycle pulse at run completion.
FAULT  out  1  sticky error flag.

Behaviour:
- Reset (RESET=0):
  - State goes to IDLE.
  - CLOCK_INHIBIT=1, COUNTER_RESET=1 (combinational from RESET).
  - PHASE_IDX=0, TOTAL=0, BUSY=0, DONE=0, FAULT=0.
  - Reset mid-run aborts the run immediately; no DONE is produced.
- Registers:
  - phase_q samples PHASE_IN every edge.
  - PHASE_IDX is the encoding of phase_q.
  - adv = (PHASE_IN != phase_q).
- States:
  - IDLE: inhibit=1. START=1 moves to CLEAR, latches TERMINAL into T, and clears TOTAL and ISSUED.
  - CLEAR (1 cycle): COUNTER_RESET=1, inhibit=1. Always moves to ARM.
  - ARM (1 cycle): inhibit=1. Moves to DONE_ST if T=0, otherwise to RUN.
  - RUN: CLOCK_INHIBIT = (ISSUED==T), combinational from registers. ISSUED increments on every edge where inhibit=0. TOTAL increments on every edge where adv=1. Moves to DRAIN on the edge where ISSUED reaches T.
  - DRAIN: inhibit=1. TOTAL absorbs the final advance. Moves to DONE_ST when TOTAL==T after that edge.
  - DONE_ST (1 cycle): DONE=1, inhibit=1. Moves to IDLE.
  - FAULT_ST: inhibit=1, FAULT=1. START moves to CLEAR and clears FAULT; otherwise the block stays here.
- Latency: edge 0 samples START.
  - CLEAR in cycle 1, ARM in cycle 2, RUN in cycles 3..T+2, DRAIN in cycle T+3.
  - DONE is high in cycle T+4.
  - With T=0, DONE is high in cycle 3 and the counter never advances.
- TOTAL lags ISSUED by exactly one cycle. TOTAL never exceeds T.
- TOTAL and PHASE_IDX hold their values in IDLE until the next START.
- START outside IDLE/FAULT_ST is ignored. Changes to TERMINAL after capture are ignored.
- Wrap-around: a 7->0 phase step counts as one ordinary step. The counter may wrap any number of times per run.
- ISSUED/TOTAL cannot overflow, because they stop at T ≤ 2^CNT_W−1.

Optional Feature:
- Macro: PHASE_FAULT_CHECK_EN
- Defined: checks are active in ARM, RUN and DRAIN. Any failure moves to FAULT_ST on the next edge, with TOTAL frozen. Checks:
  - PHASE_IN not one-hot.
  - CARRY_IN != (phase index < 4).
  - In ARM, PHASE_IN != 8'h01.
  - adv=1 with PHASE_IN != rotate-left-1 of phase_q.
  - In DRAIN, adv=1 after TOTAL==T.
  - In RUN, adv=0 on a cycle following an issued step.
- Undefined: no checks, FAULT is tied to 0, and FAULT_ST is unreachable. A non-one-hot PHASE_IN encodes to the index of its lowest set bit.

Decomposition:
- Shared package octal_ctrl_pkg, containing:
  - State enum: IDLE, CLEAR, ARM, RUN, DRAIN, DONE_ST, FAULT_ST.
  - PHASE_W=8 and IDX_W=3.
  - CARRY_HIGH_MAX=3.
  - Rotate-left helper.
- One sub-module: onehot8_encoder. Combinational 8->3, lowest-set-bit priority, with a valid_onehot flag. Used for PHASE_IDX and the fault checks.

Test Plan:
- Reset/defaults: hold RESET=0 for 3 cycles -> CLOCK_INHIBIT=1, COUNTER_RESET=1, TOTAL=0, BUSY=0, DONE=0, FAULT=0; release -> COUNTER_RESET=0.
- Basic run: TERMINAL=5 with the counter model attached, START pulse -> CLOCK_INHIBIT low for exactly 5 cycles, DONE in cycle 9, TOTAL=5, PHASE_IDX=5.
- Wrap: TERMINAL=19 -> counter wraps twice, DONE in cycle 23, TOTAL=19, PHASE_IDX=3, CARRY_IN high at the end.
- Zero/ignore: TERMINAL=0 -> DONE in cycle 3 with no inhibit release. Separately, a second START in RUN is ignored and TOTAL is unchanged.
- Fault (macro defined): force PHASE_IN=8'h05 in RUN -> FAULT=1 next cycle, CLOCK_INHIBIT=1, TOTAL frozen. START -> FAULT clears, new run completes normally.
- Async reset mid-run: RESET=0 in RUN with TOTAL=3 -> immediate IDLE, TOTAL=0, no DONE pulse, COUNTER_RESET=1.
